// File: rtl/pool2d_relu_mc_pkg.sv
// pool_pkg: mode encoding, FSM states and width helpers for 2x2 pooling.
// POOL_AVG_MODE_EN widens the pair buffer for average pooling.
package pool_pkg;

  typedef enum logic {
    MODE_MAX = 1'b0,
    MODE_AVG = 1'b1
  } mode_e;

  typedef logic [1:0] state_t;

  localparam state_t S_TOP  = 2'd0;
  localparam state_t S_BOT  = 2'd1;
  localparam state_t S_SKIP = 2'd2;

`ifdef POOL_AVG_MODE_EN
  localparam int PAIR_EXT = 1;
`else
  localparam int PAIR_EXT = 0;
`endif
  localparam int SUM_EXT = 2;

  function automatic int pair_w(input int dw);
    return dw + PAIR_EXT;
  endfunction

  function automatic int sum_w(input int dw);
    return dw + SUM_EXT;
  endfunction

endpackage

// File: rtl/pool2d_relu_mc_if.sv
// Stream-in / stream-out handshake bundle around the pooling block.
// master = source plus sink side; slave = the pooling block side.
interface pool2d_relu_mc_if #(
  parameter int W = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic         out_last;
  logic [W-1:0] out_data;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_last
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_last
  );
endinterface

// File: rtl/pool2d_relu_mc_lane.sv
// pool_lane: one channel of pair reduce, window combine, shift and ReLU.
// Average path exists only with POOL_AVG_MODE_EN.
module pool_lane
  import pool_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic                      iMode,
  input  logic                      iReluEn,
  input  logic [DATA_W-1:0]         iLeft,
  input  logic [DATA_W-1:0]         iRight,
  input  logic [pair_w(DATA_W)-1:0] iPair,
  output logic [pair_w(DATA_W)-1:0] oPair,
  output logic [DATA_W-1:0]         oRes
);

  logic signed [DATA_W-1:0] l;
  logic signed [DATA_W-1:0] r;
  logic signed [DATA_W-1:0] top;
  logic signed [DATA_W-1:0] bot;
  logic signed [DATA_W-1:0] mx;
  logic signed [DATA_W-1:0] res;

  assign l   = iLeft;
  assign r   = iRight;
  assign top = iPair[DATA_W-1:0];
  assign bot = (l > r) ? l : r;
  assign mx  = (top > bot) ? top : bot;

`ifdef POOL_AVG_MODE_EN
  localparam int SW = sum_w(DATA_W);
  logic [SW-1:0] sum4;

  // sign-extended adds; the 4-sum cannot overflow SW bits
  assign sum4 = {iPair[DATA_W], iPair}
              + {{2{l[DATA_W-1]}}, l}
              + {{2{r[DATA_W-1]}}, r};

  assign oPair = iMode ? ({l[DATA_W-1], l} + {r[DATA_W-1], r})
                       : {bot[DATA_W-1], bot};
  assign res   = iMode ? sum4[SW-1:2] : mx;
`else
  logic unused_mode;
  assign unused_mode = iMode;
  assign oPair       = bot;
  assign res         = mx;
`endif

  assign oRes = (iReluEn && res[DATA_W-1]) ? '0 : res;

endmodule

// File: rtl/pool2d_relu_mc.sv
// pool2d_relu_mc: streaming 2x2/stride-2 max/avg pooling with optional ReLU.
// Average mode compiled in only with POOL_AVG_MODE_EN.
module pool2d_relu_mc
  import pool_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int IMG_W  = 26,
  parameter int IMG_H  = 26,
  parameter int CH     = 4
) (
  input  logic                 iClk,
  input  logic                 iRsn,
  input  logic                 iInValid,
  output logic                 oInReady,
  input  logic [CH*DATA_W-1:0] iData,
  input  logic                 iMode,
  input  logic                 iReluEn,
  output logic                 oOutValid,
  input  logic                 iOutReady,
  output logic [CH*DATA_W-1:0] oData,
  output logic                 oLast
);

  localparam int OW = IMG_W / 2;
  localparam int PW = pair_w(DATA_W);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam int BW = (OW > 1) ? $clog2(OW) : 1;

  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [CW-1:0] COL_OUT  = CW'(2 * OW - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [RW-1:0] ROW_PEN  = RW'(IMG_H - 2);
  localparam logic [RW-1:0] ROW_OUT  = RW'(2 * (IMG_H / 2) - 1);
  localparam bit            H_ODD    = (IMG_H % 2) == 1;

  state_t             state;
  logic [CW-1:0]      col;
  logic [RW-1:0]      row;
  logic [BW-1:0]      bcol;
  mode_e              mode_q;
  logic               relu_q;
  logic [CH*DATA_W-1:0] hold_q;
  logic [CH*PW-1:0]   pbuf [OW];
  logic [CH*PW-1:0]   pair_rd;
  logic [CH*PW-1:0]   pair_wr;
  logic [CH*DATA_W-1:0] res;

  logic acc;
  logic row_end;
  logic frame_end;
  logic first;
  logic produce;

  assign oInReady  = !oOutValid || iOutReady;
  assign acc       = iInValid && oInReady;
  assign row_end   = col == COL_LAST;
  assign frame_end = row_end && (row == ROW_LAST);
  assign first     = (row == '0) && (col == '0);
  assign produce   = acc && (state == S_BOT) && col[0];
  assign pair_rd   = pbuf[bcol];

  for (genvar k = 0; k < CH; k++) begin : g_lane
    pool_lane #(
      .DATA_W (DATA_W)
    ) u_lane (
      .iMode   (mode_q == MODE_AVG),
      .iReluEn (relu_q),
      .iLeft   (hold_q[k*DATA_W +: DATA_W]),
      .iRight  (iData[k*DATA_W +: DATA_W]),
      .iPair   (pair_rd[k*PW +: PW]),
      .oPair   (pair_wr[k*PW +: PW]),
      .oRes    (res[k*DATA_W +: DATA_W])
    );
  end

  // mode and ReLU are frozen on pixel (0,0); first use is at col 1
  always_ff @(posedge iClk) begin
    if (!iRsn) begin
      state  <= S_TOP;
      col    <= '0;
      row    <= '0;
      bcol   <= '0;
      mode_q <= MODE_MAX;
      relu_q <= 1'b0;
      hold_q <= '0;
    end else if (acc) begin
      if (first) begin
        mode_q <= mode_e'(iMode);
        relu_q <= iReluEn;
      end
      hold_q <= iData;
      if (row_end) begin
        col  <= '0;
        bcol <= '0;
        row  <= frame_end ? '0 : row + 1'b1;
        unique case (1'b1)
          state == S_TOP:
            state <= S_BOT;
          state == S_BOT:
            state <= (H_ODD && row == ROW_PEN) ? S_SKIP : S_TOP;
          default:
            state <= S_TOP;
        endcase
      end else begin
        col <= col + 1'b1;
        if (col[0]) bcol <= bcol + 1'b1;
      end
    end
  end

  always_ff @(posedge iClk) begin
    if (acc && state == S_TOP && col[0]) begin
      pbuf[bcol] <= pair_wr;
    end
  end

  // a new result may replace a beat being accepted this same cycle
  always_ff @(posedge iClk) begin
    if (!iRsn) begin
      oOutValid <= 1'b0;
      oLast     <= 1'b0;
      oData     <= '0;
    end else if (produce) begin
      oOutValid <= 1'b1;
      oData     <= res;
      oLast     <= (row == ROW_OUT) && (col == COL_OUT);
    end else if (iOutReady) begin
      oOutValid <= 1'b0;
      oLast     <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pool2d_relu_mc.sv
// Directed bench for pool2d_relu_mc: 4x2, 5x5 and 4-lane instances.
// Expected values are hand-computed; average cases follow POOL_AVG_MODE_EN.
module tb_pool2d_relu_mc;

`ifdef POOL_AVG_MODE_EN
  localparam bit AVG = 1'b1;
`else
  localparam bit AVG = 1'b0;
`endif

  localparam int MAXV = 32'h7fffffff;
  localparam int MINV = 32'h80000000;

  logic clk = 1'b0;
  logic rsn;
  logic mode;
  logic relu;
  int   n_cmp = 0;
  int   n_err = 0;

  logic [127:0] pxq[$];
  logic [128:0] qa[$];
  logic [128:0] qb[$];
  logic [128:0] qc[$];

  always #5 clk = ~clk;

  pool2d_relu_mc_if #(.W(32))  ba ();
  pool2d_relu_mc_if #(.W(32))  bb ();
  pool2d_relu_mc_if #(.W(128)) bc ();

  pool2d_relu_mc #(
    .DATA_W(32), .IMG_W(4), .IMG_H(2), .CH(1)
  ) dut_a (
    .iClk(clk), .iRsn(rsn),
    .iInValid(ba.in_valid), .oInReady(ba.in_ready),
    .iData(ba.in_data), .iMode(mode), .iReluEn(relu),
    .oOutValid(ba.out_valid), .iOutReady(ba.out_ready),
    .oData(ba.out_data), .oLast(ba.out_last)
  );

  pool2d_relu_mc #(
    .DATA_W(32), .IMG_W(5), .IMG_H(5), .CH(1)
  ) dut_b (
    .iClk(clk), .iRsn(rsn),
    .iInValid(bb.in_valid), .oInReady(bb.in_ready),
    .iData(bb.in_data), .iMode(mode), .iReluEn(relu),
    .oOutValid(bb.out_valid), .iOutReady(bb.out_ready),
    .oData(bb.out_data), .oLast(bb.out_last)
  );

  pool2d_relu_mc #(
    .DATA_W(32), .IMG_W(4), .IMG_H(2), .CH(4)
  ) dut_c (
    .iClk(clk), .iRsn(rsn),
    .iInValid(bc.in_valid), .oInReady(bc.in_ready),
    .iData(bc.in_data), .iMode(mode), .iReluEn(relu),
    .oOutValid(bc.out_valid), .iOutReady(bc.out_ready),
    .oData(bc.out_data), .oLast(bc.out_last)
  );

  always @(negedge clk) begin
    if (ba.out_valid && ba.out_ready)
      qa.push_back({ba.out_last, 96'd0, ba.out_data});
    if (bb.out_valid && bb.out_ready)
      qb.push_back({bb.out_last, 96'd0, bb.out_data});
    if (bc.out_valid && bc.out_ready)
      qc.push_back({bc.out_last, bc.out_data});
  end

  function automatic logic [127:0] w32(input int v);
    return {96'd0, 32'(v)};
  endfunction

  function automatic logic [127:0] pk(input int a, input int b,
                                      input int c, input int d);
    return {32'(d), 32'(c), 32'(b), 32'(a)};
  endfunction

  task automatic chk(input string tag, input logic [127:0] obs,
                     input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int d, input logic [127:0] v);
    int   n;
    logic acc;
    n   = 0;
    acc = 1'b0;
    if (d == 0) begin
      ba.in_valid = 1'b1; ba.in_data = v[31:0];
    end else if (d == 1) begin
      bb.in_valid = 1'b1; bb.in_data = v[31:0];
    end else begin
      bc.in_valid = 1'b1; bc.in_data = v;
    end
    while (!acc && n < 40) begin
      @(negedge clk);
      acc = (d == 0) ? ba.in_ready :
            (d == 1) ? bb.in_ready : bc.in_ready;
      @(posedge clk); #1;
      n++;
    end
    ba.in_valid = 1'b0;
    bb.in_valid = 1'b0;
    bc.in_valid = 1'b0;
    if (!acc) chk($sformatf("push_timeout_d%0d", d), 128'(acc), 128'd1);
  endtask

  task automatic pop_chk(input int d, input string tag,
                         input logic [127:0] ed, input logic el);
    logic [128:0] e;
    int sz;
    sz = (d == 0) ? qa.size() : (d == 1) ? qb.size() : qc.size();
    if (sz == 0) begin
      chk({tag, "_present"}, 128'(sz), 128'd1);
      return;
    end
    if (d == 0) e = qa.pop_front();
    else if (d == 1) e = qb.pop_front();
    else e = qc.pop_front();
    chk(tag, e[127:0], ed);
    chk({tag, "_last"}, 128'(e[128]), 128'(el));
  endtask

  task automatic send_frame(input int d, input logic m, input logic r);
    mode = m;
    relu = r;
    foreach (pxq[i]) push(d, pxq[i]);
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic load_base();
    pxq = {w32(1), w32(-5), w32(3), w32(2),
           w32(4), w32(0), w32(-7), w32(-1)};
  endtask

  task automatic load_lanes();
    pxq = {pk(1, MINV, -1, 7),  pk(-5, MAXV, 5, 7),
           pk(3, MINV, -3, 7),  pk(2, MINV, -2, 7),
           pk(4, MAXV, -4, 7),  pk(0, MAXV, 0, 7),
           pk(-7, MINV, 7, 7),  pk(-1, MINV, 1, 7)};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rsn  = 1'b0;
    mode = 1'b0;
    relu = 1'b0;
    ba.in_valid = 1'b0; ba.in_data = '0; ba.out_ready = 1'b1;
    bb.in_valid = 1'b0; bb.in_data = '0; bb.out_ready = 1'b1;
    bc.in_valid = 1'b0; bc.in_data = '0; bc.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", 128'(ba.out_valid), 128'd0);
    chk("rst_last", 128'(ba.out_last), 128'd0);
    chk("rst_data", 128'(bc.out_data), 128'd0);
    chk("rst_ready", 128'(ba.in_ready), 128'd1);
    @(posedge clk); #1;
    rsn = 1'b1;

    // A1: max, ReLU on, latency from bottom-right beat
    load_base();
    mode = 1'b0;
    relu = 1'b1;
    foreach (pxq[i]) begin
      push(0, pxq[i]);
      if (i == 4) chk("a1_lat_pre", 128'(ba.out_valid), 128'd0);
      if (i == 5) begin
        chk("a1_lat_valid", 128'(ba.out_valid), 128'd1);
        chk("a1_lat_data", 128'(ba.out_data), w32(4));
      end
    end
    repeat (4) @(posedge clk);
    #1;
    pop_chk(0, "a1_w0", w32(4), 1'b0);
    pop_chk(0, "a1_w1", w32(3), 1'b1);
    chk("a1_cnt", 128'(qa.size()), 128'd0);

    // A2/A3: all-negative window, ReLU on then off
    pxq = {w32(-3), w32(-8), w32(-2), w32(-9),
           w32(-4), w32(-6), w32(-5), w32(-1)};
    send_frame(0, 1'b0, 1'b1);
    pop_chk(0, "a2_w0", w32(0), 1'b0);
    pop_chk(0, "a2_w1", w32(0), 1'b1);
    send_frame(0, 1'b0, 1'b0);
    pop_chk(0, "a3_w0", w32(-3), 1'b0);
    pop_chk(0, "a3_w1", w32(-1), 1'b1);

    // A4/A5: average request (max when average is not built)
    load_base();
    send_frame(0, 1'b1, 1'b0);
    pop_chk(0, "a4_w0", AVG ? w32(0) : w32(4), 1'b0);
    pop_chk(0, "a4_w1", AVG ? w32(-1) : w32(3), 1'b1);
    send_frame(0, 1'b1, 1'b1);
    pop_chk(0, "a5_w0", AVG ? w32(0) : w32(4), 1'b0);
    pop_chk(0, "a5_w1", AVG ? w32(0) : w32(3), 1'b1);
    chk("a_cnt", 128'(qa.size()), 128'd0);

    // B1: 5x5 ramp with output back-pressure on the first result
    pxq.delete();
    for (int i = 0; i < 25; i++) pxq.push_back(w32(i));
    mode = 1'b0;
    relu = 1'b0;
    bb.out_ready = 1'b0;
    for (int i = 0; i < 7; i++) push(1, pxq[i]);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk($sformatf("b1_hold_valid%0d", k), 128'(bb.out_valid), 128'd1);
      chk($sformatf("b1_hold_data%0d", k), 128'(bb.out_data), w32(6));
      chk($sformatf("b1_hold_rdy%0d", k), 128'(bb.in_ready), 128'd0);
    end
    @(posedge clk); #1;
    bb.out_ready = 1'b1;
    for (int i = 7; i < 25; i++) push(1, pxq[i]);
    repeat (4) @(posedge clk);
    #1;
    pop_chk(1, "b1_w0", w32(6), 1'b0);
    pop_chk(1, "b1_w1", w32(8), 1'b0);
    pop_chk(1, "b1_w2", w32(16), 1'b0);
    pop_chk(1, "b1_w3", w32(18), 1'b1);
    chk("b1_cnt", 128'(qb.size()), 128'd0);

    // B2: wrap to next frame; ReLU changed after pixel 0 is ignored
    pxq.delete();
    for (int i = 0; i < 25; i++) pxq.push_back(w32(2 * i - 20));
    relu = 1'b1;
    push(1, pxq[0]);
    relu = 1'b0;
    for (int i = 1; i < 25; i++) push(1, pxq[i]);
    repeat (4) @(posedge clk);
    #1;
    pop_chk(1, "b2_w0", w32(0), 1'b0);
    pop_chk(1, "b2_w1", w32(0), 1'b0);
    pop_chk(1, "b2_w2", w32(12), 1'b0);
    pop_chk(1, "b2_w3", w32(16), 1'b1);
    chk("b2_cnt", 128'(qb.size()), 128'd0);

    // C: reset while a result is pending in the bottom row
    load_lanes();
    mode = 1'b0;
    relu = 1'b0;
    bc.out_ready = 1'b0;
    for (int i = 0; i < 6; i++) push(2, pxq[i]);
    chk("c_pending", 128'(bc.out_valid), 128'd1);
    rsn = 1'b0;
    @(posedge clk); #1;
    rsn = 1'b1;
    @(negedge clk);
    chk("c_rst_valid", 128'(bc.out_valid), 128'd0);
    chk("c_rst_data", bc.out_data, 128'd0);
    chk("c_rst_last", 128'(bc.out_last), 128'd0);
    @(posedge clk); #1;
    bc.out_ready = 1'b1;

    // C1/C2: four independent lanes, extremes, ReLU off then on
    send_frame(2, AVG, 1'b0);
    pop_chk(2, "c1_w0",
            AVG ? pk(0, 32'h3fffffff, 0, 7) : pk(4, MAXV, 5, 7), 1'b0);
    pop_chk(2, "c1_w1",
            AVG ? pk(-1, MINV, 0, 7) : pk(3, MINV, 7, 7), 1'b1);
    send_frame(2, AVG, 1'b1);
    pop_chk(2, "c2_w0",
            AVG ? pk(0, 32'h3fffffff, 0, 7) : pk(4, MAXV, 5, 7), 1'b0);
    pop_chk(2, "c2_w1",
            AVG ? pk(0, 0, 0, 7) : pk(3, 0, 7, 7), 1'b1);
    chk("c_cnt", 128'(qc.size()), 128'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pool2d_relu_mc.md
POOL2D_RELU_MC -- requirements
Module: pool2d_relu_mc

Interface
REQ-001 SHALL have parameter DATA_W, default 32: signed sample width per channel.
REQ-002 SHALL have parameter IMG_W, default 26: input columns per row (>=2).
REQ-003 SHALL have parameter IMG_H, default 26: input rows per frame (>=2).
REQ-004 SHALL have parameter CH, default 4: parallel channel lanes packed per input beat.
REQ-005 SHALL have port iClk, input, 1: the single clock; all logic on its rising edge.
REQ-006 SHALL have port iRsn, input, 1: synchronous, active-low reset.
REQ-007 SHALL have port iInValid, input, 1: input beat valid.
REQ-008 SHALL have port oInReady, output, 1: block accepts a beat this cycle.
REQ-009 SHALL have port iData, input, CH*DATA_W: lane k at bits [k*DATA_W +: DATA_W], signed.
REQ-010 SHALL have port iMode, input, 1: 0 = 2x2 max, 1 = 2x2 average; sampled at frame start only.
REQ-011 SHALL have port iReluEn, input, 1: 1 = clamp negative results to 0; sampled at frame start only.
REQ-012 SHALL have port oOutValid, output, 1: output beat valid.
REQ-013 SHALL have port iOutReady, input, 1: downstream accepts the output beat.
REQ-014 SHALL have port oData, output, CH*DATA_W: pooled result per lane, same packing as iData.
REQ-015 SHALL have port oLast, output, 1: marks the final pooled beat of a frame.

Function
REQ-016 SHALL accept a beat when iInValid && oInReady; oInReady = !oOutValid || iOutReady.
REQ-017 SHALL hold oData, oLast and oOutValid stable while oOutValid && !iOutReady.
REQ-018 SHALL scan raster order, stride 2, non-overlapping windows; output count per frame (IMG_W/2)*(IMG_H/2), integer division.
REQ-019 SHALL use states S_TOP (even row), S_BOT (odd row), S_SKIP (trailing odd row when IMG_H odd); S_TOP->S_BOT, then S_BOT->S_TOP or, when IMG_H is odd and the next row is the last, S_BOT->S_SKIP; S_SKIP->S_TOP. Each transition SHALL occur on acceptance of the row's last beat.
REQ-020 SHALL in S_TOP store, per lane and per output column, a reduced pair: max(a,b) in max mode, a+b (DATA_W+1 bits) in average mode; buffer depth IMG_W/2.
REQ-021 SHALL in S_BOT hold the left pixel; on accepting the right pixel, combine it with the held pixel and the stored pair, and register the result so oOutValid rises the next cycle (latency 1 cycle from the bottom-right beat).
REQ-022 SHALL in average mode compute the 4-sample sum at DATA_W+2 bits and arithmetic-shift right by 2 (floor toward -inf).
REQ-023 SHALL, when iReluEn, output 0 for any negative lane result; otherwise pass the signed result unchanged.
REQ-024 SHALL consume, when IMG_W is odd, the last column of every row with no output, and consume S_SKIP rows with no output.
REQ-025 SHALL assert oLast with the final output beat of the frame and wrap counters to row 0, col 0 on acceptance of the frame's last input beat.
REQ-026 SHALL, on simultaneous output acceptance and production of a new result, load the new result in the same cycle with no bubble.

Reset
REQ-027 SHALL on iRsn low clear state to S_TOP, column and row counters to 0, oOutValid, oLast and oData to 0, and the mode and ReLU latches to 0; line-buffer contents are don't-care.
REQ-028 SHALL, on reset mid-frame, discard the partial frame; the first beat after reset is pixel (0,0).

Configuration
REQ-029 SHALL compile in average mode only when macro POOL_AVG_MODE_EN is defined; without it iMode is ignored, the pair buffer is DATA_W wide, and max mode is always used.

Structure
REQ-030 SHALL place the mode encoding, the state enum, and sum-width helper constants in shared package pool_pkg.
REQ-031 SHALL implement the per-lane datapath (pair reduce, combine, shift, ReLU) as sub-module pool_lane, instantiated CH times; control and counters stay in the top.

Verification
REQ-032 SHALL cover: IMG_W=4, IMG_H=2, CH=1, max, ReLU on; rows [1,-5,3,2],[4,0,-7,-1] -> outputs 4,3, oLast on the second.
REQ-033 SHALL cover: the same data in average mode -> (1-5+4+0)>>2=0, (3+2-7-1)>>2=-1 with ReLU off, and 0 with ReLU on.
REQ-034 SHALL cover: IMG_W=5, IMG_H=5, max; ramp input 0..24 -> outputs 6,8,16,18; column 4 and row 4 are dropped; oLast on 18.
REQ-035 SHALL cover: iOutReady held low for 5 cycles while an output is pending -> oData stable, oInReady low, no beat lost; all expected beats appear afterwards.
REQ-036 SHALL cover: CH=4 with distinct per-lane data, including DATA_W extremes (-2^31, 2^31-1) -> independent correct lane results with no overflow in average mode.
REQ-037 SHALL cover: reset asserted mid-S_BOT -> oOutValid 0 the next cycle; a full subsequent frame pools correctly.
